// File: rtl/synth_ctrl_regs_if.sv
// Avalon-MM slave bundle for the synth control register block.
// master drives addr/byte-enable/read/write/cs/writedata; slave returns readdata.
interface synth_ctrl_regs_if;
  logic [7:0]  AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic        AVL_CS;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_ADDR, AVL_BYTE_EN, AVL_READ,
    output AVL_WRITE, AVL_CS, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_ADDR, AVL_BYTE_EN, AVL_READ,
    input  AVL_WRITE, AVL_CS, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/synth_ctrl_regs.sv
// Double-banked synth voice settings: CPU writes shadow, a commit copies
// shadow->active on the next SAMPLE_TICK so all outputs change atomically.
// Ports: CLK, RESET (sync, active-high), SAMPLE_TICK, avl (Avalon slave),
// SHAPE0/1, ATTACK/DECAY/SUSTAIN/RLEASE, KEY/FREQ/AMP1/AMP0 (voice v at
// slice v), COMMIT_BUSY, IRQ.
// Macro SYNTH_CTRL_IRQ_EN: enables IE bit and registered IRQ = IE & DONE.
module synth_ctrl_regs #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = 7
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         SAMPLE_TICK,
  synth_ctrl_regs_if.slave             avl,
  output logic [1:0]                   SHAPE0,
  output logic [1:0]                   SHAPE1,
  output logic [15:0]                  ATTACK,
  output logic [15:0]                  DECAY,
  output logic [15:0]                  SUSTAIN,
  output logic [15:0]                  RLEASE,
  output logic [NUM_VOICES-1:0]        KEY,
  output logic [FREQ_W*NUM_VOICES-1:0] FREQ,
  output logic [16*NUM_VOICES-1:0]     AMP1,
  output logic [16*NUM_VOICES-1:0]     AMP0,
  output logic                         COMMIT_BUSY,
  output logic                         IRQ
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef struct packed {
    logic [1:0]                         shape0;
    logic [1:0]                         shape1;
    logic [15:0]                        attack;
    logic [15:0]                        decay;
    logic [15:0]                        sustain;
    logic [15:0]                        rlease;
    logic [NUM_VOICES-1:0]              key;
    logic [NUM_VOICES-1:0][FREQ_W-1:0]  freq;
    logic [NUM_VOICES-1:0][15:0]        amp1;
    logic [NUM_VOICES-1:0][15:0]        amp0;
  } bank_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COPY
  } state_t;

  bank_t       shadow_q, shadow_d;
  bank_t       active_q, active_d;
  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ie_q;

  logic          wr, rd;
  logic [3:0]    grp, vidx;
  logic [VW-1:0] vi;
  logic          v_ok;
  logic          is_glb, is_key, is_frq, is_am1, is_am0;
  logic [31:0]   rval, wval;
  logic          commit_req, done_clr;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

`ifdef SYNTH_CTRL_IRQ_EN
  logic ie_d, irq_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= ie_q & done_q;
    end
  end

  assign IRQ = irq_q;
`else
  assign ie_q = 1'b0;
  assign IRQ  = 1'b0;
`endif

  always_comb begin
    wr     = avl.AVL_WRITE & avl.AVL_CS;
    rd     = avl.AVL_READ & avl.AVL_CS;
    grp    = avl.AVL_ADDR[7:4];
    vidx   = avl.AVL_ADDR[3:0];
    vi     = vidx[VW-1:0];
    v_ok   = 32'(vidx) < NUM_VOICES;
    is_glb = avl.AVL_ADDR[7:3] == 5'd0;
    is_key = (grp == 4'h4) && v_ok;
    is_frq = (grp == 4'h5) && v_ok;
    is_am1 = (grp == 4'h6) && v_ok;
    is_am0 = (grp == 4'h7) && v_ok;

    rval = '0;
    unique case (1'b1)
      is_glb: begin
        case (avl.AVL_ADDR[2:0])
          3'd0: rval = 32'(shadow_q.shape0);
          3'd1: rval = 32'(shadow_q.shape1);
          3'd2: rval = 32'(shadow_q.attack);
          3'd3: rval = 32'(shadow_q.decay);
          3'd4: rval = 32'(shadow_q.sustain);
          3'd5: rval = 32'(shadow_q.rlease);
          3'd6: rval = {30'd0, ie_q, 1'b0};
          default: rval = {30'd0, done_q, COMMIT_BUSY};
        endcase
      end
      is_key: rval = 32'(shadow_q.key[vi]);
      is_frq: rval = 32'(shadow_q.freq[vi]);
      is_am1: rval = 32'(shadow_q.amp1[vi]);
      is_am0: rval = 32'(shadow_q.amp0[vi]);
      default: rval = '0;
    endcase

    // old value is the zero-extended shadow, so unwritten lanes keep it
    wval       = merge(rval, avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
    shadow_d   = shadow_q;
    commit_req = 1'b0;
    done_clr   = 1'b0;
`ifdef SYNTH_CTRL_IRQ_EN
    ie_d = ie_q;
`endif

    if (wr) begin
      unique case (1'b1)
        is_glb: begin
          case (avl.AVL_ADDR[2:0])
            3'd0: shadow_d.shape0  = wval[1:0];
            3'd1: shadow_d.shape1  = wval[1:0];
            3'd2: shadow_d.attack  = wval[15:0];
            3'd3: shadow_d.decay   = wval[15:0];
            3'd4: shadow_d.sustain = wval[15:0];
            3'd5: shadow_d.rlease  = wval[15:0];
            3'd6: begin
              commit_req = wval[0];
`ifdef SYNTH_CTRL_IRQ_EN
              ie_d = wval[1];
`endif
            end
            default: done_clr = avl.AVL_BYTE_EN[0] & avl.AVL_WRITEDATA[1];
          endcase
        end
        is_key: shadow_d.key[vi]  = wval[0];
        is_frq: shadow_d.freq[vi] = wval[FREQ_W-1:0];
        is_am1: shadow_d.amp1[vi] = wval[15:0];
        is_am0: shadow_d.amp0[vi] = wval[15:0];
        default: ;
      endcase
    end

    rdata_d = rd ? rval : rdata_q;

    state_d  = state_q;
    active_d = active_q;
    unique case (state_q)
      IDLE:    if (commit_req) state_d = PENDING;
      PENDING: if (SAMPLE_TICK) state_d = COPY;
      COPY: begin
        // pre-write shadow, so a write landing this cycle waits for next commit
        active_d = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (done_q & ~done_clr) | (state_q == COPY);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_q <= '0;
      active_q <= '0;
      state_q  <= IDLE;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      state_q  <= state_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avl.AVL_READDATA = rdata_q;
  assign COMMIT_BUSY      = state_q != IDLE;
  assign SHAPE0           = active_q.shape0;
  assign SHAPE1           = active_q.shape1;
  assign ATTACK           = active_q.attack;
  assign DECAY            = active_q.decay;
  assign SUSTAIN          = active_q.sustain;
  assign RLEASE           = active_q.rlease;
  assign KEY              = active_q.key;
  assign FREQ             = active_q.freq;
  assign AMP1             = active_q.amp1;
  assign AMP0             = active_q.amp0;

endmodule

// File: tb/tb_synth_ctrl_regs.sv
// Bench for synth_ctrl_regs: a 4-voice and a 2-voice instance get the same
// bus stimulus; read results are checked through an expected-value queue.
module tb_synth_ctrl_regs;

`ifdef SYNTH_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  logic SAMPLE_TICK;

  always #5 CLK = ~CLK;

  synth_ctrl_regs_if a4 ();
  synth_ctrl_regs_if a2 ();

  logic [1:0]  sh0_4, sh1_4, sh0_2, sh1_2;
  logic [15:0] att_4, dec_4, sus_4, rel_4;
  logic [15:0] att_2, dec_2, sus_2, rel_2;
  logic [3:0]  key_4;
  logic [1:0]  key_2;
  logic [27:0] frq_4;
  logic [13:0] frq_2;
  logic [63:0] am1_4, am0_4;
  logic [31:0] am1_2, am0_2;
  logic        bsy_4, irq_4, bsy_2, irq_2;

  synth_ctrl_regs #(.NUM_VOICES(4), .FREQ_W(7)) dut4 (
    .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .avl(a4),
    .SHAPE0(sh0_4), .SHAPE1(sh1_4), .ATTACK(att_4), .DECAY(dec_4),
    .SUSTAIN(sus_4), .RLEASE(rel_4), .KEY(key_4), .FREQ(frq_4),
    .AMP1(am1_4), .AMP0(am0_4), .COMMIT_BUSY(bsy_4), .IRQ(irq_4)
  );

  synth_ctrl_regs #(.NUM_VOICES(2), .FREQ_W(7)) dut2 (
    .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .avl(a2),
    .SHAPE0(sh0_2), .SHAPE1(sh1_2), .ATTACK(att_2), .DECAY(dec_2),
    .SUSTAIN(sus_2), .RLEASE(rel_2), .KEY(key_2), .FREQ(frq_2),
    .AMP1(am1_2), .AMP0(am0_2), .COMMIT_BUSY(bsy_2), .IRQ(irq_2)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          d2;
  } rd_t;

  rd_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic [7:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic r, input logic w);
    a4.AVL_ADDR = addr;  a2.AVL_ADDR = addr;
    a4.AVL_WRITEDATA = wd; a2.AVL_WRITEDATA = wd;
    a4.AVL_BYTE_EN = be; a2.AVL_BYTE_EN = be;
    a4.AVL_READ = r;     a2.AVL_READ = r;
    a4.AVL_WRITE = w;    a2.AVL_WRITE = w;
    a4.AVL_CS = r | w;   a2.AVL_CS = r | w;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd,
                    input logic [3:0] be = 4'hF);
    bus(addr, wd, be, 1'b0, 1'b1);
    step();
    bus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [7:0] addr,
                    input logic [31:0] exp, input bit d2 = 1'b0);
    rd_t e;
    sb.push_back('{tag, exp, d2});
    bus(addr, 32'h0, 4'h0, 1'b1, 1'b0);
    step();
    bus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, 64'(e.d2 ? a2.AVL_READDATA : a4.AVL_READDATA), 64'(e.exp));
    end
  endtask

  task automatic tick();
    SAMPLE_TICK = 1'b1;
    step();
    SAMPLE_TICK = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    SAMPLE_TICK = 1'b0;
    bus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0);
    step();
    step();
    RESET = 1'b0;
    chk("rst_key", 64'(key_4), 64'h0);
    chk("rst_freq", 64'(frq_4), 64'h0);
    chk("rst_busy", 64'(bsy_4), 64'h0);
    chk("rst_irq", 64'(irq_4), 64'h0);
    chk("rst_rdata", 64'(a4.AVL_READDATA), 64'h0);

    // shadow only: no commit, outputs stay 0
    wr(8'h50, 32'h3C);
    for (int i = 0; i < 100; i++) tick();
    chk("nocommit_freq", 64'(frq_4[6:0]), 64'h0);
    rd("rd_freq0", 8'h50, 32'h3C);
    step();
    chk("rd_hold", 64'(a4.AVL_READDATA), 64'h3C);

    // keys + globals, commit on tick
    for (int v = 0; v < 4; v++) wr(8'h40 + 8'(v), 32'h1);
    wr(8'h02, 32'hBEEF);
    wr(8'h00, 32'hFF);
    rd("shape0_trunc", 8'h00, 32'h3);
    wr(8'h06, 32'h1);
    chk("busy_pend", 64'(bsy_4), 64'h1);
    chk("key_pend", 64'(key_4), 64'h0);
    tick();
    chk("busy_copy", 64'(bsy_4), 64'h1);
    chk("key_copy", 64'(key_4), 64'h0);
    step();
    chk("key_all", 64'(key_4), 64'hF);
    chk("key_v2", 64'(key_2), 64'h3);
    chk("busy_done", 64'(bsy_4), 64'h0);
    chk("attack", 64'(att_4), 64'hBEEF);
    chk("freq_v2", 64'(frq_2), 64'h3C);
    rd("status_done", 8'h07, 32'h2);
    wr(8'h07, 32'h2);
    rd("status_clr", 8'h07, 32'h0);

    // byte lanes
    wr(8'h60, 32'h1234);
    wr(8'h60, 32'hABCD, 4'b0001);
    rd("amp1_be", 8'h60, 32'h12CD);

    // commit with simultaneous tick, then a second request while pending
    bus(8'h06, 32'h1, 4'hF, 1'b0, 1'b1);
    SAMPLE_TICK = 1'b1;
    step();
    bus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0);
    SAMPLE_TICK = 1'b0;
    chk("sametick_busy", 64'(bsy_4), 64'h1);
    step();
    step();
    chk("sametick_nocopy", 64'(am1_4[15:0]), 64'h0);
    wr(8'h06, 32'h1);
    tick();
    step();
    chk("amp1_commit", 64'(am1_4[15:0]), 64'h12CD);
    rd("one_done", 8'h07, 32'h2);
    wr(8'h07, 32'h2);
    for (int i = 0; i < 3; i++) tick();
    rd("no_second", 8'h07, 32'h0);

    // write during COPY keeps active at the pre-write value
    wr(8'h70, 32'h1111);
    wr(8'h06, 32'h1);
    tick();
    wr(8'h70, 32'h2222);
    chk("copy_race_act", 64'(am0_4[15:0]), 64'h1111);
    rd("copy_race_shd", 8'h70, 32'h2222);
    wr(8'h07, 32'h2);

    // interrupt
    wr(8'h06, 32'h2);
    rd("ctrl_ie", 8'h06, IRQ_EN ? 32'h2 : 32'h0);
    wr(8'h06, 32'h3);
    tick();
    step();
    step();
    chk("irq_set", 64'(irq_4), 64'(IRQ_EN));
    wr(8'h07, 32'h2);
    step();
    chk("irq_clr", 64'(irq_4), 64'h0);
    rd("status_irqclr", 8'h07, 32'h0);

    // out-of-range voice on the 2-voice instance
    wr(8'h53, 32'h5);
    rd("oor_rd2", 8'h53, 32'h0, 1'b1);
    rd("inrange_rd4", 8'h53, 32'h5);
    rd("oor_key2", 8'h43, 32'h0, 1'b1);

    // reset while pending aborts the commit
    wr(8'h71, 32'h5555);
    wr(8'h06, 32'h1);
    chk("pend_before_rst", 64'(bsy_4), 64'h1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rr_key", 64'(key_4), 64'h0);
    chk("rr_freq", 64'(frq_4), 64'h0);
    chk("rr_amp1", 64'(am1_4), 64'h0);
    chk("rr_attack", 64'(att_4), 64'h0);
    chk("rr_shape0", 64'(sh0_4), 64'h0);
    chk("rr_busy", 64'(bsy_4), 64'h0);
    chk("rr_irq", 64'(irq_4), 64'h0);
    chk("rr_rdata", 64'(a4.AVL_READDATA), 64'h0);
    tick();
    step();
    chk("rr_nocopy", 64'(am0_4), 64'h0);
    chk("rr_idle", 64'(bsy_4), 64'h0);
    rd("rr_shadow", 8'h71, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
